// File: rtl/bp_pkg.sv
// Shared branch-predictor types: counter encoding, resolve-unit FSM states, table-update record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bp_pkg;

   // Default predictor geometry; table index is pc[BP_BTB_IDX_W+1:2].
   localparam int BP_XLEN      = 32;
   localparam int BP_BTB_IDX_W = 6;

   // 2-bit bimodal counter: MSB is the predicted direction.
   typedef logic [1:0] ctr2_t;

   localparam ctr2_t CTR_SNT = 2'b00;   // strongly not-taken
   localparam ctr2_t CTR_WNT = 2'b01;   // weakly not-taken
   localparam ctr2_t CTR_WT  = 2'b10;   // weakly taken
   localparam ctr2_t CTR_ST  = 2'b11;   // strongly taken

   // RUN: resolving normally. SHADOW: wrong-path bubbles after a redirect.
   typedef enum logic {
      RUN    = 1'b0,
      SHADOW = 1'b1
   } bru_state_t;

   // One BTB/BHT write as seen by the IF-stage tables (default geometry).
   typedef struct packed {
      logic [BP_BTB_IDX_W-1:0]           idx;
      logic [BP_XLEN-BP_BTB_IDX_W-3:0]   tag;
      logic [BP_XLEN-1:0]                target;
      ctr2_t                             ctr;
   } bp_update_t;

endpackage

// File: rtl/bp_sat_ctr2.sv
// 2-bit saturating counter step: increment on taken, decrement on not-taken.
// Latency: combinational.
// Backpressure: none.
// Ports: ctr (current value), inc (1=count up, 0=count down), nxt (saturated result).
module bp_sat_ctr2 (
   input  logic [1:0] ctr,
   input  logic       inc,
   output logic [1:0] nxt
);
   import bp_pkg::*;

   always_comb begin
      nxt = ctr;
      if (inc) begin
         if (ctr != CTR_ST) nxt = ctr + 2'd1;
      end else begin
         if (ctr != CTR_SNT) nxt = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: compares carried prediction with outcome, redirects on mispredict, writes predictor tables.
// Latency: redirect combinational (same cycle); table update registered (1 cycle).
// Backpressure: ex_stall freezes everything (no redirect/update/FSM step); redirect starts SHADOW_CYCLES ignored cycles.
// Optional: define BRU_STATS_EN to build saturating branch/mispredict counters; otherwise stat ports read 0.
// Ports:
//   clk, rstn                       clock, async active-low reset
//   ex_valid, ex_stall              EX occupancy and pipeline stall
//   ex_is_branch, ex_is_jump        instruction class (jump = always taken)
//   ex_pc                           PC of the EX instruction
//   ex_pred_taken/target/ctr        prediction made in IF
//   ex_act_taken/target             resolved outcome
//   redirect_o, redirect_pc_o       flush request and correct next PC (pc is 0 when no redirect)
//   upd_valid_o/idx_o/tag_o/target_o/ctr_o   one-cycle table write strobe and held payload
//   stat_branches_o, stat_mispred_o resolved / mispredicted counts
module branch_resolve_unit #(
   parameter int XLEN          = 32,
   parameter int BTB_IDX_W     = bp_pkg::BP_BTB_IDX_W,
   parameter int SHADOW_CYCLES = 2,
   parameter int CNT_W         = 32
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        ex_valid,
   input  logic                        ex_stall,
   input  logic                        ex_is_branch,
   input  logic                        ex_is_jump,
   input  logic [XLEN-1:0]             ex_pc,
   input  logic                        ex_pred_taken,
   input  logic [XLEN-1:0]             ex_pred_target,
   input  logic [1:0]                  ex_pred_ctr,
   input  logic                        ex_act_taken,
   input  logic [XLEN-1:0]             ex_act_target,
   output logic                        redirect_o,
   output logic [XLEN-1:0]             redirect_pc_o,
   output logic                        upd_valid_o,
   output logic [BTB_IDX_W-1:0]        upd_idx_o,
   output logic [XLEN-BTB_IDX_W-3:0]   upd_tag_o,
   output logic [XLEN-1:0]             upd_target_o,
   output logic [1:0]                  upd_ctr_o,
   output logic [CNT_W-1:0]            stat_branches_o,
   output logic [CNT_W-1:0]            stat_mispred_o
);
   import bp_pkg::*;

   // Shadow counter holds values 0..SHADOW_CYCLES-1.
   localparam int SC_W = (SHADOW_CYCLES > 1) ? $clog2(SHADOW_CYCLES) : 1;

   bru_state_t        state;
   logic [SC_W-1:0]   shadow_cnt;

   logic              cf;
   logic              act_taken_eff;
   logic              mispred;
   logic [1:0]        sat_nxt;
   logic [1:0]        new_ctr;

   // A control-flow instruction is resolved only when live, not stalled and not on the wrong path.
   assign cf            = ex_valid & ~ex_stall & (ex_is_branch | ex_is_jump) & (state == RUN);
   assign act_taken_eff = ex_is_jump | ex_act_taken;

   // A correctly predicted direction still mispredicts if the taken target differs.
   assign mispred = cf & ((act_taken_eff != ex_pred_taken) |
                          (act_taken_eff & (ex_pred_target != ex_act_target)));

   assign redirect_o    = mispred;
   assign redirect_pc_o = mispred ? (act_taken_eff ? ex_act_target : ex_pc + XLEN'(4)) : '0;

   bp_sat_ctr2 u_sat_ctr2 (
      .ctr (ex_pred_ctr),
      .inc (act_taken_eff),
      .nxt (sat_nxt)
   );

   // Jumps are unconditional, so they are pinned to strongly-taken.
   assign new_ctr = ex_is_jump ? CTR_ST : sat_nxt;

   // Wrong-path suppression FSM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= RUN;
         shadow_cnt <= '0;
      end else if (state == RUN) begin
         if (mispred) begin
            state      <= SHADOW;
            shadow_cnt <= SC_W'(SHADOW_CYCLES - 1);
         end
      end else begin
         // Stalled cycles do not retire wrong-path slots, so they do not count.
         if (!ex_stall) begin
            if (shadow_cnt == '0) state <= RUN;
            else                  shadow_cnt <= shadow_cnt - SC_W'(1);
         end
      end
   end

   // Table update: strobe for one cycle per resolved instruction, payload held between writes.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         upd_valid_o  <= 1'b0;
         upd_idx_o    <= '0;
         upd_tag_o    <= '0;
         upd_target_o <= '0;
         upd_ctr_o    <= '0;
      end else begin
         upd_valid_o <= cf;
         if (cf) begin
            upd_idx_o    <= ex_pc[BTB_IDX_W+1:2];
            upd_tag_o    <= ex_pc[XLEN-1:BTB_IDX_W+2];
            upd_target_o <= ex_act_target;
            upd_ctr_o    <= new_ctr;
         end
      end
   end

   // Instruction-aligned PCs: the byte-offset bits never reach the tables.
   logic unused_pc_lsb;
   assign unused_pc_lsb = &{1'b0, ex_pc[1:0]};

`ifdef BRU_STATS_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         stat_branches_o <= '0;
         stat_mispred_o  <= '0;
      end else begin
         if (cf && !(&stat_branches_o))     stat_branches_o <= stat_branches_o + CNT_W'(1);
         if (mispred && !(&stat_mispred_o)) stat_mispred_o  <= stat_mispred_o + CNT_W'(1);
      end
   end
`else
   assign stat_branches_o = '0;
   assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: redirect, table update, shadow, stall, reset and statistics.
// Latency: inputs driven 1 ns after posedge; redirect checked mid-cycle, update checked after the next posedge.
// Backpressure: exercised via ex_stall, including stall while in the shadow window.
module tb_branch_resolve_unit;

   logic        clk;
   logic        rstn;
   logic        ex_valid;
   logic        ex_stall;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic [31:0] ex_pc;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic [1:0]  ex_pred_ctr;
   logic        ex_act_taken;
   logic [31:0] ex_act_target;
   logic        redirect_o;
   logic [31:0] redirect_pc_o;
   logic        upd_valid_o;
   logic [5:0]  upd_idx_o;
   logic [23:0] upd_tag_o;
   logic [31:0] upd_target_o;
   logic [1:0]  upd_ctr_o;
   logic [31:0] stat_branches_o;
   logic [31:0] stat_mispred_o;

   int checks   = 0;
   int failures = 0;

   branch_resolve_unit dut (
      .clk             (clk),
      .rstn            (rstn),
      .ex_valid        (ex_valid),
      .ex_stall        (ex_stall),
      .ex_is_branch    (ex_is_branch),
      .ex_is_jump      (ex_is_jump),
      .ex_pc           (ex_pc),
      .ex_pred_taken   (ex_pred_taken),
      .ex_pred_target  (ex_pred_target),
      .ex_pred_ctr     (ex_pred_ctr),
      .ex_act_taken    (ex_act_taken),
      .ex_act_target   (ex_act_target),
      .redirect_o      (redirect_o),
      .redirect_pc_o   (redirect_pc_o),
      .upd_valid_o     (upd_valid_o),
      .upd_idx_o       (upd_idx_o),
      .upd_tag_o       (upd_tag_o),
      .upd_target_o    (upd_target_o),
      .upd_ctr_o       (upd_ctr_o),
      .stat_branches_o (stat_branches_o),
      .stat_mispred_o  (stat_mispred_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ex_valid       = 1'b0;
      ex_stall       = 1'b0;
      ex_is_branch   = 1'b0;
      ex_is_jump     = 1'b0;
      ex_pc          = '0;
      ex_pred_taken  = 1'b0;
      ex_pred_target = '0;
      ex_pred_ctr    = '0;
      ex_act_taken   = 1'b0;
      ex_act_target  = '0;
   endtask

   task automatic drive(input logic br, input logic jmp, input logic ptk,
                        input logic [31:0] pc, input logic [31:0] ptgt, input logic [1:0] pctr,
                        input logic atk, input logic [31:0] atgt);
      ex_valid       = 1'b1;
      ex_stall       = 1'b0;
      ex_is_branch   = br;
      ex_is_jump     = jmp;
      ex_pc          = pc;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
      ex_pred_ctr    = pctr;
      ex_act_taken   = atk;
      ex_act_target  = atgt;
   endtask

   initial begin
      rstn = 1'b0;
      idle();
      #12;
      chk("rst_redir",  redirect_o, 0);
      chk("rst_rpc",    redirect_pc_o, 0);
      chk("rst_uvld",   upd_valid_o, 0);
      chk("rst_uctr",   upd_ctr_o, 0);
      chk("rst_utgt",   upd_target_o, 0);
      chk("rst_sbr",    stat_branches_o, 0);
      chk("rst_smp",    stat_mispred_o, 0);
      tick();
      rstn = 1'b1;
      tick();

      // T1: predicted NT, actually taken -> redirect to target, counter 1->2.
      drive(1, 0, 0, 32'h100, 32'h0, 2'd1, 1, 32'h140);
      #1;
      chk("t1_redir", redirect_o, 1);
      chk("t1_rpc",   redirect_pc_o, 32'h140);
      tick(); idle();
      chk("t1_uvld", upd_valid_o, 1);
      chk("t1_uctr", upd_ctr_o, 2);
      chk("t1_uidx", upd_idx_o, 0);
      chk("t1_utag", upd_tag_o, 1);
      chk("t1_utgt", upd_target_o, 32'h140);
      tick();
      chk("t1_upulse", upd_valid_o, 0);
      tick();

      // T2: correct taken prediction, counter saturates at 3.
      drive(1, 0, 1, 32'h104, 32'h200, 2'd3, 1, 32'h200);
      #1;
      chk("t2_redir", redirect_o, 0);
      chk("t2_rpc",   redirect_pc_o, 0);
      tick(); idle();
      chk("t2_uvld", upd_valid_o, 1);
      chk("t2_uctr", upd_ctr_o, 3);
      chk("t2_uidx", upd_idx_o, 1);
      chk("t2_utgt", upd_target_o, 32'h200);

      // T3: predicted T, actually NT -> redirect to pc+4; then two shadow cycles ignore a mispredict.
      drive(1, 0, 1, 32'h108, 32'h300, 2'd2, 0, 32'h300);
      #1;
      chk("t3_redir", redirect_o, 1);
      chk("t3_rpc",   redirect_pc_o, 32'h10C);
      tick();
      drive(1, 0, 0, 32'h200, 32'h0, 2'd1, 1, 32'h400);
      #1;
      chk("t3_uvld",    upd_valid_o, 1);
      chk("t3_uctr",    upd_ctr_o, 1);
      chk("t3_uidx",    upd_idx_o, 2);
      chk("t3_shadow1", redirect_o, 0);
      tick();
      chk("t3_shadow2", redirect_o, 0);
      chk("t3_nouvld1", upd_valid_o, 0);
      tick(); idle();
      chk("t3_nouvld2", upd_valid_o, 0);

      // T4: JALR, target mismatch -> redirect to resolved target, counter forced to 3.
      drive(0, 1, 1, 32'h10, 32'h80, 2'd0, 0, 32'h90);
      #1;
      chk("t4_redir", redirect_o, 1);
      chk("t4_rpc",   redirect_pc_o, 32'h90);
      tick(); idle();
      chk("t4_uvld", upd_valid_o, 1);
      chk("t4_uctr", upd_ctr_o, 3);
      chk("t4_uidx", upd_idx_o, 4);
      chk("t4_utgt", upd_target_o, 32'h90);
      tick(); tick();

      // T5: valid non-control-flow instruction produces nothing.
      drive(0, 0, 0, 32'h50, 32'h0, 2'd1, 1, 32'h99);
      #1;
      chk("t5_redir", redirect_o, 0);
      tick(); idle();
      chk("t5_uvld", upd_valid_o, 0);
      chk("t5_uhold", upd_target_o, 32'h90);

      // T6: mispredict held under stall for 3 cycles, then exactly one redirect and one update.
      drive(1, 0, 0, 32'h300, 32'h0, 2'd0, 1, 32'h340);
      ex_stall = 1'b1;
      #1;
      chk("t6_stall_redir", redirect_o, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_stall_uvld", upd_valid_o, 0);
         chk("t6_stall_redir2", redirect_o, 0);
      end
      ex_stall = 1'b0;
      #1;
      chk("t6_redir", redirect_o, 1);
      chk("t6_rpc",   redirect_pc_o, 32'h340);
      tick();
      // Stall inside the shadow window must freeze the countdown.
      drive(1, 0, 0, 32'h500, 32'h0, 2'd1, 1, 32'h540);
      ex_stall = 1'b1;
      #1;
      chk("t6_uvld", upd_valid_o, 1);
      chk("t6_uctr", upd_ctr_o, 1);
      chk("t6_uidx", upd_idx_o, 0);
      chk("t6_utag", upd_tag_o, 3);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_once", upd_valid_o, 0);
      end
      ex_stall = 1'b0;
      #1;
      chk("t6_shadow_hold", redirect_o, 0);
      tick();
      chk("t6_shadow_last", redirect_o, 0);
      tick(); idle();
      chk("t6_noupd", upd_valid_o, 0);

      // T7: correct NT prediction, counter saturates at 0.
      drive(1, 0, 0, 32'h10C, 32'h0, 2'd0, 0, 32'h180);
      #1;
      chk("t7_redir", redirect_o, 0);
      tick(); idle();
      chk("t7_uvld", upd_valid_o, 1);
      chk("t7_uctr", upd_ctr_o, 0);
      chk("t7_uidx", upd_idx_o, 3);
      chk("t7_utgt", upd_target_o, 32'h180);

      // Resolved so far: T1,T2,T3,T4,T6,T7; mispredicted: T1,T3,T4,T6.
`ifdef BRU_STATS_EN
      chk("stat_br", stat_branches_o, 6);
      chk("stat_mp", stat_mispred_o, 4);
`else
      chk("stat_br_off", stat_branches_o, 0);
      chk("stat_mp_off", stat_mispred_o, 0);
`endif

      // T8: reset in the shadow window with an update outstanding.
      drive(1, 0, 0, 32'h400, 32'h0, 2'd1, 1, 32'h480);
      #1;
      chk("t8_redir", redirect_o, 1);
      tick(); idle();
      chk("t8_uvld", upd_valid_o, 1);
      rstn = 1'b0;
      #1;
      chk("t8_rst_uvld", upd_valid_o, 0);
      chk("t8_rst_utgt", upd_target_o, 0);
      chk("t8_rst_sbr",  stat_branches_o, 0);
      chk("t8_rst_smp",  stat_mispred_o, 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
      drive(1, 0, 0, 32'h600, 32'h0, 2'd1, 1, 32'h640);
      #1;
      chk("t8_run_redir", redirect_o, 1);
      chk("t8_run_rpc",   redirect_pc_o, 32'h640);
      tick(); idle();
      chk("t8_run_uvld", upd_valid_o, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
